// File: rtl/alu_tr_voter_pkg.sv
// Shared opcodes, FSM encoding and the 2-of-3 vote helper for the time-redundant ALU.
package alu_tr_voter_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EX1  = 3'd1;
    localparam logic [2:0] S_EX2  = 3'd2;
    localparam logic [2:0] S_EX3  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] SEL_R1 = 2'd0;
    localparam logic [1:0] SEL_R2 = 2'd1;
    localparam logic [1:0] SEL_R3 = 2'd2;

    typedef struct packed {
        logic [1:0] sel;
        logic       fault;
        logic       uncorrect;
    } vote_t;

    // Majority pick from pairwise equalities; r2 wins over r1 when both agree with someone.
    function automatic vote_t vote3(input logic eq12, input logic eq23, input logic eq13);
        vote_t v;
        v.fault     = !(eq12 && eq23);
        v.uncorrect = 1'b0;
        if (eq12 || eq23) begin
            v.sel = SEL_R2;
        end else if (eq13) begin
            v.sel = SEL_R1;
        end else begin
            v.sel       = SEL_R3;
            v.uncorrect = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/alu_tr_voter_if.sv
// Operation/result handshake bundle between the voter and its producer/consumer.
interface alu_tr_voter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       alu_ctrl;
    logic             mode_tmr;
    logic [WIDTH-1:0] inj_mask;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             negative;
    logic             fault_det;
    logic             uncorrect;
    logic             spare_active;
    logic [CNT_W-1:0] fault_cnt;

    modport master (
        output in_valid, a, b, alu_ctrl, mode_tmr, inj_mask, out_ready,
        input  in_ready, out_valid, result, zero, carry, overflow, negative,
               fault_det, uncorrect, spare_active, fault_cnt
    );

    modport slave (
        input  in_valid, a, b, alu_ctrl, mode_tmr, inj_mask, out_ready,
        output in_ready, out_valid, result, zero, carry, overflow, negative,
               fault_det, uncorrect, spare_active, fault_cnt
    );
endinterface

// File: rtl/alu_tr_voter_core.sv
// Combinational ALU core: result plus carry/overflow; zero/negative are derived downstream.
module alu_tr_voter_core
    import alu_tr_voter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       ctrl_i,
    output logic [WIDTH-1:0] res_c_o,
    output logic             carry_c_o,
    output logic             ovf_c_o
);
    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0] sum_w;
    logic [WIDTH:0] diff_w;

    always_comb begin
        sum_w     = {1'b0, a_i} + {1'b0, b_i};
        // Subtract as a + ~b + 1 so bit WIDTH is the no-borrow carry.
        diff_w    = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
        res_c_o   = '0;
        carry_c_o = 1'b0;
        ovf_c_o   = 1'b0;
        case (ctrl_i)
            OP_ADD: begin
                res_c_o   = sum_w[WIDTH-1:0];
                carry_c_o = sum_w[WIDTH];
                ovf_c_o   = (a_i[MSB] == b_i[MSB]) && (sum_w[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                res_c_o   = diff_w[WIDTH-1:0];
                carry_c_o = diff_w[WIDTH];
                ovf_c_o   = (a_i[MSB] != b_i[MSB]) && (diff_w[MSB] != a_i[MSB]);
            end
            OP_AND:  res_c_o = a_i & b_i;
            OP_OR:   res_c_o = a_i | b_i;
            OP_SLT:  res_c_o = WIDTH'($signed(a_i) < $signed(b_i));
            default: res_c_o = '0;
        endcase
    end
endmodule

// File: rtl/alu_tr_voter.sv
// Time-redundant ALU wrapper: duplicate run on the active core, tie-break on the other core, spare swap.
module alu_tr_voter
    import alu_tr_voter_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned FAULT_THRESH = 3,
    parameter int unsigned CNT_W        = 8
) (
    input logic           clk,
    input logic           rst,
    alu_tr_voter_if.slave bus
);
    localparam int unsigned    MSB      = WIDTH - 1;
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(FAULT_THRESH);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             tmr_q, tmr_d;
    logic [WIDTH-1:0] r1_q, r1_d, r2_q, r2_d;
    logic             c1_q, c1_d, v1_q, v1_d, c2_q, c2_d, v2_q, v2_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, neg_q, neg_d;
    logic             fd_q, fd_d, uc_q, uc_d, spare_q, spare_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, consec_q, consec_d;

    logic [WIDTH-1:0] res0, res1, act_res, oth_res, sel_res;
    logic             c0, c1, v0, v1, act_c, act_v, oth_c, oth_v, sel_c, sel_v;
    logic [CNT_W-1:0] cnt_inc, consec_inc;
    vote_t            vote;

    alu_tr_voter_core #(.WIDTH(WIDTH)) core0 (
        .a_i(a_q), .b_i(b_q), .ctrl_i(ctrl_q),
        .res_c_o(res0), .carry_c_o(c0), .ovf_c_o(v0)
    );

    alu_tr_voter_core #(.WIDTH(WIDTH)) core1 (
        .a_i(a_q), .b_i(b_q), .ctrl_i(ctrl_q),
        .res_c_o(res1), .carry_c_o(c1), .ovf_c_o(v1)
    );

    // Role select: test injection only ever disturbs the active core.
    always_comb begin
        act_res = (spare_q ? res1 : res0) ^ bus.inj_mask;
        act_c   = spare_q ? c1 : c0;
        act_v   = spare_q ? v1 : v0;
        oth_res = spare_q ? res0 : res1;
        oth_c   = spare_q ? c0 : c1;
        oth_v   = spare_q ? v0 : v1;
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        consec_inc = (consec_q == '1) ? consec_q : consec_q + CNT_W'(1);
        vote       = vote3(r1_q == r2_q, r2_q == oth_res, r1_q == oth_res);
        case (vote.sel)
            SEL_R1:  begin sel_res = r1_q;    sel_c = c1_q;  sel_v = v1_q;  end
            SEL_R2:  begin sel_res = r2_q;    sel_c = c2_q;  sel_v = v2_q;  end
            default: begin sel_res = oth_res; sel_c = oth_c; sel_v = oth_v; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        tmr_d    = tmr_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        c1_d     = c1_q;
        v1_d     = v1_q;
        c2_d     = c2_q;
        v2_d     = v2_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        fd_d     = fd_q;
        uc_d     = uc_q;
        spare_d  = spare_q;
        cnt_d    = cnt_q;
        consec_d = consec_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    ctrl_d  = bus.alu_ctrl;
                    tmr_d   = bus.mode_tmr;
                    state_d = S_EX1;
                end
            end
            S_EX1: begin
                r1_d    = act_res;
                c1_d    = act_c;
                v1_d    = act_v;
                state_d = S_EX2;
            end
            S_EX2: begin
                r2_d = act_res;
                c2_d = act_c;
                v2_d = act_v;
                if ((act_res == r1_q) && !tmr_q) begin
                    result_d = act_res;
                    zero_d   = (act_res == '0);
                    neg_d    = act_res[MSB];
                    carry_d  = act_c;
                    ovf_d    = act_v;
                    fd_d     = 1'b0;
                    uc_d     = 1'b0;
                    consec_d = '0;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_EX3;
                end
            end
            S_EX3: begin
                result_d = sel_res;
                zero_d   = (sel_res == '0);
                neg_d    = sel_res[MSB];
                carry_d  = sel_c;
                ovf_d    = sel_v;
                fd_d     = vote.fault;
                uc_d     = vote.uncorrect;
                if (vote.fault) begin
                    cnt_d    = cnt_inc;
                    consec_d = consec_inc;
                    // Swap takes effect on the next accept, since cores are only used in EX states.
                    if (consec_inc >= THRESH_C) spare_d = 1'b1;
                end else begin
                    consec_d = '0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            ctrl_q      <= '0;
            tmr_q       <= 1'b0;
            r1_q        <= '0;
            r2_q        <= '0;
            c1_q        <= 1'b0;
            v1_q        <= 1'b0;
            c2_q        <= 1'b0;
            v2_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
            fd_q        <= 1'b0;
            uc_q        <= 1'b0;
            spare_q     <= 1'b0;
            cnt_q       <= '0;
            consec_q    <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctrl_q      <= ctrl_d;
            tmr_q       <= tmr_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            c1_q        <= c1_d;
            v1_q        <= v1_d;
            c2_q        <= c2_d;
            v2_q        <= v2_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            neg_q       <= neg_d;
            fd_q        <= fd_d;
            uc_q        <= uc_d;
            spare_q     <= spare_d;
            cnt_q       <= cnt_d;
            consec_q    <= consec_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.result       = result_q;
    assign bus.zero         = zero_q;
    assign bus.carry        = carry_q;
    assign bus.overflow     = ovf_q;
    assign bus.negative     = neg_q;
    assign bus.fault_det    = fd_q;
    assign bus.uncorrect    = uc_q;
    assign bus.spare_active = spare_q;
    assign bus.fault_cnt    = cnt_q;
endmodule

// File: tb/tb_alu_tr_voter.sv
// Scoreboard bench for alu_tr_voter: reference ALU + vote model, latency, hold and reset checks.
module tb_alu_tr_voter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        z, c, v, n, fd, uc, sp;
        logic [7:0]  cnt;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned m_cnt    = 0;
    int unsigned m_consec = 0;
    logic        m_spare  = 1'b0;

    alu_tr_voter_if #(.WIDTH(32), .CNT_W(8)) bus ();

    alu_tr_voter #(.WIDTH(32), .FAULT_THRESH(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                    output logic [31:0] r, output logic c, output logic v);
        logic [32:0] w;
        r = '0; c = 1'b0; v = 1'b0; w = '0;
        case (op)
            3'b000: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                          v = (a[31] == b[31]) && (r[31] != a[31]); end
            3'b001: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = ~w[32];
                          v = (a[31] != b[31]) && (r[31] != a[31]); end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
    endfunction

    // Drive one operation; m1/m2/m3 are the inj_mask values during EX1/EX2/EX3, hold = cycles out_ready stays low.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input logic tmr,
                         input logic [31:0] m1, input logic [31:0] m2, input logic [31:0] m3, input int hold);
        logic [31:0] g, r1, r2, pick;
        logic        gc, gv, fault, unc;
        exp_t        e, p;
        int          lat;
        logic [31:0] held;
        ref_alu(a, b, op, g, gc, gv);
        r1 = g ^ m1;
        r2 = g ^ m2;
        fault = 1'b0; unc = 1'b0; pick = r2;
        if (tmr || r1 != r2) begin
            fault = !(r1 == r2 && r2 == g);
            if (r1 == r2 || r2 == g) pick = r2;
            else if (r1 == g)        pick = r1;
            else begin pick = g; unc = 1'b1; end
        end
        if (fault) begin
            if (m_cnt < 255) m_cnt++;
            m_consec++;
            if (m_consec >= 3) m_spare = 1'b1;
        end else m_consec = 0;
        e.res = pick; e.z = (pick == 0); e.n = pick[31]; e.c = gc; e.v = gv;
        e.fd = fault; e.uc = unc; e.cnt = 8'(m_cnt); e.sp = m_spare;
        e.lat = (tmr || r1 != r2) ? 4 : 3;
        sb_q.push_back(e);

        @(negedge clk);
        check("accept_ready", 64'(bus.in_ready), 64'd1);
        bus.a = a; bus.b = b; bus.alu_ctrl = op; bus.mode_tmr = tmr;
        bus.in_valid = 1'b1; bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        if (hold == 0) bus.in_valid = 1'b0;
        bus.inj_mask = m1;
        lat = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            bus.inj_mask = (cyc == 1) ? m2 : (cyc == 2) ? m3 : 32'd0;
            if (bus.out_valid) begin lat = cyc + 1; break; end
        end
        bus.inj_mask = '0;
        p = sb_q.pop_front();
        check("latency_edges", 64'(lat), 64'(p.lat));
        if (lat == 0) begin
            bus.in_valid = 1'b0; bus.out_ready = 1'b1;
            return;
        end
        held = bus.result;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_result", 64'(bus.result), 64'(held));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("result", 64'(bus.result), 64'(p.res));
        check("flags_zcvn", 64'({bus.zero, bus.carry, bus.overflow, bus.negative}), 64'({p.z, p.c, p.v, p.n}));
        check("fault_det", 64'(bus.fault_det), 64'(p.fd));
        check("uncorrect", 64'(bus.uncorrect), 64'(p.uc));
        check("fault_cnt", 64'(bus.fault_cnt), 64'(p.cnt));
        check("spare_active", 64'(bus.spare_active), 64'(p.sp));
        @(posedge clk); #1;
        check("valid_drop", 64'(bus.out_valid), 64'd0);
        check("ready_back", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.alu_ctrl = '0; bus.mode_tmr = 1'b0;
        bus.inj_mask = '0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_status", 64'({bus.fault_det, bus.uncorrect, bus.spare_active}), 64'd0);
        check("rst_fault_cnt", 64'(bus.fault_cnt), 64'd0);
        rst = 1'b1;

        do_op(32'h5, 32'h3, 3'b000, 1'b0, 0, 0, 0, 0);                                     // clean DMR add
        do_op(32'h8000_0000, 32'h1, 3'b001, 1'b0, 0, 32'h1, 0, 0);                         // EX2 transient
        do_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010, 1'b1, 32'h4, 32'h4, 32'h4, 0);         // common-mode
        do_op(32'hFFFF_FFFF, 32'h1, 3'b101, 1'b0, 0, 0, 0, 5);                             // slt with backpressure
        for (int i = 0; i < 3; i++)
            do_op(32'h1234_0000 + 32'(i), 32'h0000_4321, 3'b011, 1'b0, 32'h10, 0, 0, 0);   // EX1 transients
        do_op(32'h7FFF_FFFF, 32'h1, 3'b000, 1'b0, 32'hFF, 0, 0, 0);                        // after swap

        // Reset while in EX2 abandons the operation.
        @(negedge clk);
        bus.a = 32'h11; bus.b = 32'h22; bus.alu_ctrl = 3'b000; bus.mode_tmr = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1; bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_fault_cnt", 64'(bus.fault_cnt), 64'd0);
        check("midrst_spare", 64'(bus.spare_active), 64'd0);
        m_cnt = 0; m_consec = 0; m_spare = 1'b0;
        @(negedge clk); rst = 1'b1;

        do_op(32'h0000_00FF, 32'h0000_0001, 3'b000, 1'b0, 0, 0, 0, 0);                     // after reset
        do_op(32'h0000_0003, 32'h0000_0003, 3'b001, 1'b0, 32'h1, 32'h2, 0, 0);             // all three differ
        do_op(32'hDEAD_BEEF, 32'h1, 3'b111, 1'b0, 0, 0, 0, 0);                             // undefined opcode
        do_op(32'h8000_0000, 32'h8000_0000, 3'b000, 1'b1, 0, 0, 0, 0);                     // TMR clean, carry+ovf

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
